// File: rtl/nice_icb_sram_rsp.sv
// ICB-attached 2^DEPTH_W x 32 SRAM responder with an OUTS-deep in-order response FIFO.
// Latency: response valid the cycle after acceptance. Backpressure: cmd_ready drops at FIFO full.
// Optional NICE_ICB_RSP_STALL_EN adds LFSR-driven ready/valid stalls; default build has none.
module nice_icb_sram_rsp #(
    parameter int          DEPTH_W   = 10,
    parameter int          OUTS      = 4,
    parameter logic [31:0] BASE_ADDR = 32'h1000_0000
) (
    input  logic        nice_clk,
    input  logic        nice_rst_n,
    input  logic        nice_icb_cmd_valid,
    output logic        nice_icb_cmd_ready,
    input  logic [31:0] nice_icb_cmd_addr,
    input  logic        nice_icb_cmd_read,
    input  logic [31:0] nice_icb_cmd_wdata,
    input  logic [3:0]  nice_icb_cmd_wmask,
    input  logic [1:0]  nice_icb_cmd_size,
    output logic        nice_icb_rsp_valid,
    input  logic        nice_icb_rsp_ready,
    output logic [31:0] nice_icb_rsp_rdata,
    output logic        nice_icb_rsp_err
);

    localparam int PTR_W = $clog2(OUTS);
    localparam int CNT_W = PTR_W + 1;
    localparam int WORDS = 1 << DEPTH_W;

    logic [31:0]      mem_q [WORDS];
    logic [31:0]      fifo_rdata_q [OUTS];
    logic [OUTS-1:0]  fifo_err_q;
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic               push, pop;
    logic               cnt_lt, cnt_nz;
    logic               in_win, cmd_err;
    logic [DEPTH_W-1:0] cmd_idx;
    logic [31:0]        push_rdata;

    // Window is aligned to its own size, so an upper-bit compare is the range check.
    assign in_win  = (nice_icb_cmd_addr >> (DEPTH_W + 2)) == (BASE_ADDR >> (DEPTH_W + 2));
    assign cmd_err = !in_win || (nice_icb_cmd_addr[1:0] != 2'b00) || (nice_icb_cmd_size != 2'b10);
    assign cmd_idx = nice_icb_cmd_addr[DEPTH_W+1:2];

    assign cnt_lt = cnt_q < CNT_W'(OUTS);
    assign cnt_nz = cnt_q != '0;

`ifdef NICE_ICB_RSP_STALL_EN
    logic [7:0] lfsr_q, lfsr_d;
    logic       hold_q, hold_d;

    always_comb begin
        lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        hold_d = nice_icb_rsp_valid && !nice_icb_rsp_ready;
    end

    always_ff @(posedge nice_clk or negedge nice_rst_n) begin
        if (!nice_rst_n) begin
            lfsr_q <= 8'hA5;
            hold_q <= 1'b0;
        end else begin
            lfsr_q <= lfsr_d;
            hold_q <= hold_d;
        end
    end

    // A presented response stays valid until taken, regardless of the LFSR.
    assign nice_icb_cmd_ready = cnt_lt && !lfsr_q[0];
    assign nice_icb_rsp_valid = cnt_nz && (!lfsr_q[1] || hold_q);
`else
    assign nice_icb_cmd_ready = cnt_lt;
    assign nice_icb_rsp_valid = cnt_nz;
`endif

    assign push = nice_icb_cmd_valid && nice_icb_cmd_ready;
    assign pop  = nice_icb_rsp_valid && nice_icb_rsp_ready;

    assign push_rdata = (nice_icb_cmd_read && !cmd_err) ? mem_q[cmd_idx] : 32'h0;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (push) begin
            wptr_d = wptr_q + PTR_W'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge nice_clk or negedge nice_rst_n) begin
        if (!nice_rst_n) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            cnt_q      <= '0;
            fifo_err_q <= '0;
            for (int i = 0; i < OUTS; i++) begin
                fifo_rdata_q[i] <= '0;
            end
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
            if (push) begin
                fifo_rdata_q[wptr_q] <= push_rdata;
                fifo_err_q[wptr_q]   <= cmd_err;
            end
        end
    end

    // SRAM array is intentionally not reset.
    always_ff @(posedge nice_clk) begin
        if (push && !nice_icb_cmd_read && !cmd_err) begin
            for (int b = 0; b < 4; b++) begin
                if (nice_icb_cmd_wmask[b]) begin
                    mem_q[cmd_idx][8*b +: 8] <= nice_icb_cmd_wdata[8*b +: 8];
                end
            end
        end
    end

    assign nice_icb_rsp_rdata = cnt_nz ? fifo_rdata_q[rptr_q] : 32'h0;
    assign nice_icb_rsp_err   = cnt_nz ? fifo_err_q[rptr_q]   : 1'b0;

endmodule

// File: tb/tb_nice_icb_sram_rsp.sv
// Randomized scoreboard bench for nice_icb_sram_rsp against a byte-level memory model.
module tb_nice_icb_sram_rsp;

    localparam logic [31:0] BASE = 32'h1000_0000;
    localparam int          NB   = 4096;
    localparam int          OUTS = 4;

    logic        nice_clk = 1'b0;
    logic        nice_rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_addr = '0;
    logic        cmd_read = 1'b0;
    logic [31:0] cmd_wdata = '0;
    logic [3:0]  cmd_wmask = '0;
    logic [1:0]  cmd_size = 2'b10;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    nice_icb_sram_rsp dut (
        .nice_clk           (nice_clk),
        .nice_rst_n         (nice_rst_n),
        .nice_icb_cmd_valid (cmd_valid),
        .nice_icb_cmd_ready (cmd_ready),
        .nice_icb_cmd_addr  (cmd_addr),
        .nice_icb_cmd_read  (cmd_read),
        .nice_icb_cmd_wdata (cmd_wdata),
        .nice_icb_cmd_wmask (cmd_wmask),
        .nice_icb_cmd_size  (cmd_size),
        .nice_icb_rsp_valid (rsp_valid),
        .nice_icb_rsp_ready (rsp_ready),
        .nice_icb_rsp_rdata (rsp_rdata),
        .nice_icb_rsp_err   (rsp_err)
    );

    always #5 nice_clk = ~nice_clk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic [31:0] kmask;
    } exp_t;

    exp_t       sb_q[$];
    logic [7:0] m_b[NB];
    bit         m_k[NB];
    int         n_chk = 0;
    int         n_pass = 0;
    int         rdy_mode = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    always @(posedge nice_clk) begin
        #1;
        case (rdy_mode)
            0:       rsp_ready = 1'b1;
            1:       rsp_ready = 1'b0;
            default: rsp_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Monitor: inputs are stable at the falling edge, so anything seen here is what the next rising edge acts on.
    always @(negedge nice_clk) begin
        if (!nice_rst_n) begin
            sb_q.delete();
            for (int i = 0; i < NB; i++) m_k[i] = 1'b0;
            chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
            chk("rst_rsp_rdata", rsp_rdata, 32'd0);
            chk("rst_rsp_err", 32'(rsp_err), 32'd0);
`ifdef NICE_ICB_RSP_STALL_EN
            chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
`else
            chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
`endif
        end else begin
`ifdef NICE_ICB_RSP_STALL_EN
            if (cmd_ready) chk("cmd_ready_when_full", 32'(sb_q.size() < OUTS), 32'd1);
`else
            chk("cmd_ready", 32'(cmd_ready), 32'(sb_q.size() < OUTS));
            chk("rsp_valid", 32'(rsp_valid), 32'(sb_q.size() != 0));
`endif
            if (rsp_valid) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    chk("rsp_err", 32'(rsp_err), 32'(sb_q[0].err));
                    chk("rsp_rdata", rsp_rdata & sb_q[0].kmask, sb_q[0].rdata & sb_q[0].kmask);
                    if (rsp_ready) void'(sb_q.pop_front());
                end
            end
            if (cmd_valid && cmd_ready) begin
                exp_t   e;
                longint a;
                int     off;
                bit     err;
                a   = longint'(cmd_addr);
                err = (a < longint'(BASE)) || (a >= longint'(BASE) + NB) ||
                      (cmd_addr[1:0] != 2'b00) || (cmd_size != 2'b10);
                off = int'(a - longint'(BASE));
                e.rdata = '0;
                e.err   = err;
                e.kmask = '1;
                if (!err && !cmd_read) begin
                    for (int b = 0; b < 4; b++) begin
                        if (cmd_wmask[b]) begin
                            m_b[off+b] = cmd_wdata[8*b +: 8];
                            m_k[off+b] = 1'b1;
                        end
                    end
                end
                if (!err && cmd_read) begin
                    for (int b = 0; b < 4; b++) begin
                        e.rdata[8*b +: 8] = m_b[off+b];
                        e.kmask[8*b +: 8] = m_k[off+b] ? 8'hFF : 8'h00;
                    end
                end
                sb_q.push_back(e);
            end
        end
    end

    task automatic set_cmd(bit rd, logic [31:0] a, logic [31:0] wd, logic [3:0] m, logic [1:0] sz);
        cmd_read  = rd;
        cmd_addr  = a;
        cmd_wdata = wd;
        cmd_wmask = m;
        cmd_size  = sz;
        cmd_valid = 1'b1;
    endtask

    task automatic wait_accept();
        int n = 0;
        while (1) begin
            @(negedge nice_clk);
            if (cmd_ready) break;
            n++;
            if (n > 500) begin
                chk("cmd_accept_timeout", 32'd0, 32'd1);
                cmd_valid = 1'b0;
                return;
            end
        end
        @(posedge nice_clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic issue(bit rd, logic [31:0] a, logic [31:0] wd, logic [3:0] m, logic [1:0] sz);
        set_cmd(rd, a, wd, m, sz);
        wait_accept();
    endtask

    task automatic drain();
        int n = 0;
        rdy_mode = 0;
        while (sb_q.size() != 0 || rsp_valid) begin
            @(negedge nice_clk);
            n++;
            if (n > 500) begin
                chk("drain_timeout", 32'(sb_q.size()), 32'd0);
                break;
            end
        end
        @(posedge nice_clk);
        #1;
    endtask

    task automatic rand_cmd();
        logic [31:0] a;
        logic [1:0]  sz;
        int          r;
        r = $urandom_range(0, 15);
        if (r <= 11)      a = BASE + 32'(4 * $urandom_range(0, 7));
        else if (r == 12) a = BASE + 32'(4 * 1023);
        else if (r == 13) a = BASE + 32'(NB);
        else if (r == 14) a = BASE + 32'($urandom_range(1, 3)) + 32'(4 * $urandom_range(0, 7));
        else              a = BASE - 32'(4 * $urandom_range(1, 4));
        sz = ($urandom_range(0, 15) == 0) ? 2'($urandom_range(0, 3)) : 2'b10;
        issue(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)), sz);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge nice_clk);
        #2 nice_rst_n = 1'b1;
        @(posedge nice_clk);
        #1;

        // Basic write/read, partial-mask merge, error cases, empty mask.
        issue(1'b0, BASE + 8, 32'hDEAD_BEEF, 4'hF, 2'b10);
        issue(1'b1, BASE + 8, 32'h0, 4'h0, 2'b10);
        issue(1'b0, BASE + 8, 32'h1122_3344, 4'b0101, 2'b10);
        issue(1'b1, BASE + 8, 32'h0, 4'h0, 2'b10);
        issue(1'b0, BASE + 4*1023, 32'hCAFE_F00D, 4'hF, 2'b10);
        issue(1'b0, BASE + 4, 32'h0BAD_CAFE, 4'hF, 2'b10);
        issue(1'b1, BASE + 2, 32'h0, 4'h0, 2'b10);
        issue(1'b0, BASE - 4, 32'h5555_5555, 4'hF, 2'b10);
        issue(1'b0, BASE + 6, 32'h6666_6666, 4'hF, 2'b10);
        issue(1'b0, BASE + 8, 32'h7777_7777, 4'hF, 2'b01);
        issue(1'b0, BASE + NB, 32'h8888_8888, 4'hF, 2'b10);
        issue(1'b1, BASE + 4*1023, 32'h0, 4'h0, 2'b10);
        issue(1'b1, BASE + 4, 32'h0, 4'h0, 2'b10);
        issue(1'b1, BASE + 8, 32'h0, 4'h0, 2'b10);
        issue(1'b0, BASE + 8, 32'hFFFF_FFFF, 4'h0, 2'b10);
        issue(1'b1, BASE + 8, 32'h0, 4'h0, 2'b10);
        drain();

        // Fill to OUTS with responses blocked; the fifth command must wait.
        rdy_mode = 1;
        for (int i = 0; i < 4; i++) issue(1'b1, BASE + 32'(4 * i), 32'h0, 4'h0, 2'b10);
        set_cmd(1'b1, BASE + 16, 32'h0, 4'h0, 2'b10);
        repeat (3) begin
            @(negedge nice_clk);
            chk("full_cmd_ready", 32'(cmd_ready), 32'd0);
        end
        rdy_mode = 0;
        wait_accept();
        drain();

        // Occupancy held at two with simultaneous push and pop.
        rdy_mode = 1;
        issue(1'b1, BASE + 8, 32'h0, 4'h0, 2'b10);
        issue(1'b1, BASE + 4, 32'h0, 4'h0, 2'b10);
        rdy_mode = 0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            issue(1'($urandom_range(0, 1)), BASE + 32'(4 * $urandom_range(0, 7)),
                  $urandom, 4'($urandom_range(0, 15)), 2'b10);
        end
        drain();

        // Random traffic with random response backpressure and idle gaps.
        rdy_mode = 2;
        for (int i = 0; i < 300; i++) begin
            rand_cmd();
            repeat ($urandom_range(0, 2)) begin
                @(posedge nice_clk);
                #1;
            end
        end
        drain();

        // Reset with three responses pending.
        rdy_mode = 1;
        for (int i = 0; i < 3; i++) issue(1'b1, BASE + 32'(4 * i), 32'h0, 4'h0, 2'b10);
        #2 nice_rst_n = 1'b0;
        #1;
        chk("rst_imm_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_imm_rsp_rdata", rsp_rdata, 32'd0);
        repeat (2) @(posedge nice_clk);
        #2 nice_rst_n = 1'b1;
        rdy_mode = 0;
        @(posedge nice_clk);
        #1;
        issue(1'b0, BASE + 12, 32'hA1B2_C3D4, 4'hF, 2'b10);
        issue(1'b1, BASE + 12, 32'h0, 4'h0, 2'b10);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/nice_icb_sram_rsp.md
NICE_ICB_SRAM_RSP -- requirements
Module: nice_icb_sram_rsp

Interface
REQ-001 Parameter DEPTH_W, default 10, log2 of SRAM depth in 32-bit words.
REQ-002 Parameter OUTS, default 4, maximum outstanding (accepted, unreturned) responses; power of two, at least 2.
REQ-003 Parameter BASE_ADDR, default 32'h1000_0000, byte base address of the window; aligned to 4*2^DEPTH_W.
REQ-004 nice_clk  in  1  sole clock, rising edge.
REQ-005 nice_rst_n  in  1  reset, asynchronous, active-low.
REQ-006 nice_icb_cmd_valid  in  1  command valid.
REQ-007 nice_icb_cmd_ready  out  1  command accepted when valid and ready are both high.
REQ-008 nice_icb_cmd_addr  in  32  byte address.
REQ-009 nice_icb_cmd_read  in  1  1 = read, 0 = write.
REQ-010 nice_icb_cmd_wdata  in  32  write data.
REQ-011 nice_icb_cmd_wmask  in  4  byte write enables; bit i selects bits [8i+7:8i].
REQ-012 nice_icb_cmd_size  in  2  access size; only 2'b10 (word) is legal.
REQ-013 nice_icb_rsp_valid  out  1  response valid.
REQ-014 nice_icb_rsp_ready  in  1  response accepted when valid and ready are both high.
REQ-015 nice_icb_rsp_rdata  out  32  read data; 0 for writes and errors.
REQ-016 nice_icb_rsp_err  out  1  error response.

Function
REQ-017 The block SHALL hold one ICB responder SRAM of 2^DEPTH_W x 32 bits; contents are not reset.
REQ-018 Without stall injection, nice_icb_cmd_ready SHALL equal (cnt < OUTS); cnt is the response FIFO occupancy.
REQ-019 An accepted command SHALL be an error when any of the following holds: addr outside [BASE_ADDR, BASE_ADDR+4*2^DEPTH_W); addr[1:0] != 0; size != 2'b10.
REQ-020 An accepted non-error write SHALL update each SRAM byte whose wmask bit is 1 on the acceptance edge, and SHALL leave all other bytes unchanged.
REQ-021 An error write SHALL NOT modify the SRAM.
REQ-022 An accepted non-error read SHALL capture the word at index addr[DEPTH_W+1:2] on the acceptance edge.
REQ-023 Each accepted command SHALL push exactly one {rdata, err} entry into an OUTS-deep FIFO on the acceptance edge.
REQ-024 Responses SHALL be returned strictly in command acceptance order.
REQ-025 nice_icb_rsp_valid SHALL equal (cnt != 0); rdata and err SHALL come from the FIFO head.
REQ-026 Latency: a command accepted on edge N into an empty FIFO SHALL give rsp_valid high in the cycle after edge N.
REQ-027 While rsp_valid is high and rsp_ready is low, rdata and err SHALL remain stable.
REQ-028 Simultaneous push and pop SHALL leave cnt unchanged; read and write pointers SHALL wrap modulo OUTS.
REQ-029 When cnt == OUTS, cmd_ready SHALL be low, even if a pop occurs in the same cycle; there is no full-FIFO bypass.
REQ-030 A read accepted on the edge after a write to the same word SHALL return the newly written data.
REQ-031 A write with wmask == 4'b0000 and no error SHALL be a legal no-op that returns err = 0.

Reset
REQ-032 While nice_rst_n is low, the block SHALL hold cnt, pointers, rsp_valid, rsp_err and rsp_rdata at 0, with cmd_ready = 1 (cmd_ready = 0 with stall injection enabled).
REQ-033 Reset asserted mid-operation SHALL discard all pending responses immediately; SRAM contents are not guaranteed.

Configuration
REQ-034 Macro NICE_ICB_RSP_STALL_EN defined: the block SHALL include an 8-bit Fibonacci LFSR, taps 8,6,5,4, reset to 8'hA5, stepping every cycle.
REQ-035 With the macro defined, cmd_ready SHALL be (cnt < OUTS) && !lfsr[0], and rsp_valid SHALL be (cnt != 0) && !lfsr[1].
REQ-036 With the macro defined, a rsp_valid that is already high SHALL NOT drop until the handshake completes.
REQ-037 Macro undefined: no LFSR logic is present, and REQ-018/REQ-025 apply unchanged.

Verification
REQ-038 Write 32'hDEAD_BEEF to BASE_ADDR+8 with mask 4'hF, then read BASE_ADDR+8 -> write response rdata 0, err 0; read response rdata 32'hDEAD_BEEF, err 0.
REQ-039 Write 32'h1122_3344 with mask 4'b0101 over word 32'hDEAD_BEEF, then read back -> 32'hDE22_BE44.
REQ-040 Read BASE_ADDR+2, then a write to BASE_ADDR-4 -> both responses err 1, rdata 0; SRAM unchanged.
REQ-041 Hold rsp_ready low and issue 5 back-to-back reads -> 4 accepted, cmd_ready low; release rsp_ready -> 4 responses in order, then the 5th is accepted.
REQ-042 Keep the FIFO at occupancy 2 with push and pop every cycle for 100 cycles -> cnt stays 2, no response lost or reordered.
REQ-043 Drop nice_rst_n with 3 responses pending -> rsp_valid 0 immediately; after release, a new read returns only its own response.
